piso_shift_tx: RTL and testbench
================================

PISO_SHIFT_TX -- requirements
Module: piso_shift_tx

Interface
REQ-001 Parameter N, default 8, data word width in bits (N >= 2).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_data  input  N  parallel word to serialize.
REQ-005 in_valid  input  1  in_data is valid this cycle.
REQ-006 in_ready  output  1  block accepts a word this cycle.
REQ-007 shift_tick  input  1  bit-rate strobe; one strobe ends the current bit period.
REQ-008 s_out  output  1  registered serial output, LSB first.
REQ-009 busy  output  1  a frame is in progress.
REQ-010 done  output  1  one-cycle pulse when a frame's last bit period ends.

Function
REQ-011 The FSM SHALL have two states: IDLE and SHIFT.
REQ-012 A word SHALL be accepted only on a cycle where in_valid and in_ready are both 1.
REQ-013 in_ready SHALL be 1 in IDLE, and in SHIFT only on the cycle where shift_tick=1 and the bit counter is at the last bit; otherwise it SHALL be 0.
REQ-014 On accept, the shift register SHALL load in_data, the bit counter SHALL load 0, and the FSM SHALL enter or stay in SHIFT.
REQ-015 s_out SHALL equal shift-register bit 0, so data bit 0 appears on the cycle after accept.
REQ-016 In SHIFT, on shift_tick with counter < last, the register SHALL shift right one place (fill 0) and the counter SHALL increment.
REQ-017 Without shift_tick, s_out, the register and the counter SHALL hold; a bit period lasts exactly one tick interval.
REQ-018 The last bit index SHALL be N-1, or N when parity is compiled in (see REQ-026).
REQ-019 On shift_tick with counter = last, done SHALL pulse high for that one cycle.
REQ-020 On that same cycle, if a word is also accepted, the next word SHALL load with no idle gap; otherwise the FSM SHALL go to IDLE and s_out SHALL go to 0.
REQ-021 busy SHALL be 1 exactly when the state is SHIFT.
REQ-022 In IDLE, shift_tick SHALL be ignored and s_out SHALL stay 0.
REQ-023 If accept and shift_tick occur together in IDLE, the word SHALL load and the tick SHALL NOT advance it.
REQ-024 While in_ready=0, in_valid and in_data SHALL have no effect.

Reset
REQ-025 While rst=1, regardless of clk, the following SHALL hold: state IDLE, register 0, counter 0, s_out 0, busy 0, done 0, in_ready 1 (combinational from IDLE). Asserting rst mid-frame SHALL abort the frame with no done pulse.

Configuration
REQ-026 Macro PISO_PARITY_EN:
- Defined: after data bit N-1, one extra bit period SHALL carry even parity (XOR of the accepted word, captured at accept); the frame is N+1 bit periods.
- Undefined: no parity logic; the frame is N bit periods.

Structure
REQ-027 A shared package piso_pkg SHALL hold the state enum typedef (IDLE, SHIFT) and the counter-width function clog2(N+1).
REQ-028 The design SHALL be a single module with no sub-module; the FSM, counter and shift register are flat.

Verification (N=8, ticks every 4 cycles unless stated)
REQ-029 Reset mid-frame after 3 bits -> s_out=0, busy=0, in_ready=1 immediately (asynchronously); no done pulse.
REQ-030 Accept 0xA5 -> s_out sequence 1,0,1,0,0,1,0,1, each bit held 4 cycles; done pulses once; then IDLE with s_out=0.
REQ-031 in_valid held high with 0x01 then 0xFF -> in_ready pulses on the last tick; bit 0 of 0xFF follows bit 7 of 0x01 with no gap; two done pulses.
REQ-032 Ticks while idle plus in_valid=0 -> s_out stays 0 and busy stays 0; change in_data mid-frame -> the serialized word is unchanged.
REQ-033 Ticks every cycle with accept coincident with a tick in IDLE -> bit 0 is held for one full tick period.
REQ-034 With PISO_PARITY_EN, accept 0x07 -> 8 data bits then parity bit 1; accept 0x03 -> parity bit 0; done pulses after the 9th period.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and helpers for the PISO serial transmitter.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Smallest number of bits able to index v distinct values.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter, LSB first, one bit per shift_tick period.
// Optional even parity bit after the data bits when PISO_PARITY_EN is defined.
module piso_shift_tx
    import piso_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         shift_tick,
    output logic         s_out,
    output logic         busy,
    output logic         done
);

`ifdef PISO_PARITY_EN
    localparam int FRAME_W = N + 1;
`else
    localparam int FRAME_W = N;
`endif
    localparam int                LAST     = FRAME_W - 1;
    localparam int                CNT_W    = clog2(N + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(LAST);

    state_t               state;
    logic [FRAME_W-1:0]   sreg;
    logic [CNT_W-1:0]     cnt;
    logic [FRAME_W-1:0]   load_word;
    logic                 last_tick;
    logic                 accept;

`ifdef PISO_PARITY_EN
    // Parity travels as the top bit of the frame so it simply shifts out last.
    assign load_word = {^in_data, in_data};
`else
    assign load_word = in_data;
`endif

    assign last_tick = (state == SHIFT) && shift_tick && (cnt == LAST_CNT);
    assign in_ready  = (state == IDLE) || last_tick;
    assign accept    = in_valid && in_ready;
    assign done      = last_tick;
    assign busy      = (state == SHIFT);
    assign s_out     = sreg[0];

    // Accept takes priority so a word arriving on the final tick follows with no gap,
    // and a tick coinciding with a load in IDLE does not advance the fresh word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
        end else if (accept) begin
            state <= SHIFT;
            sreg  <= load_word;
            cnt   <= '0;
        end else if (last_tick) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
        end else if ((state == SHIFT) && shift_tick) begin
            sreg  <= {1'b0, sreg[FRAME_W-1:1]};
            cnt   <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Directed bench for piso_shift_tx (N=8); parity scenario built when PISO_PARITY_EN is defined.
module tb_piso_shift_tx;

    localparam int N = 8;
`ifdef PISO_PARITY_EN
    localparam int LAST = N;
`else
    localparam int LAST = N - 1;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         shift_tick = 1'b0;
    logic         s_out;
    logic         busy;
    logic         done;

    int cmp = 0;
    int err = 0;

    // Reference model state: frame in progress, captured word (with parity on top), bit index.
    logic         m_busy = 1'b0;
    logic [N:0]   m_word = '0;
    int           m_idx  = 0;
    logic         m_acc  = 1'b0;
    logic [3:0]   exp_v  = '0;

    piso_shift_tx #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .shift_tick (shift_tick),
        .s_out      (s_out),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Drive one cycle of inputs; exp_v = {s_out, busy, done, in_ready} expected this cycle.
    task automatic apply(input logic tick, input logic valid, input logic [N-1:0] data);
        logic last;
        shift_tick = tick;
        in_valid   = valid;
        in_data    = data;
        #1;
        last  = tick && m_busy && (m_idx == LAST);
        exp_v = {(m_busy ? m_word[m_idx] : 1'b0), m_busy, last, (!m_busy || last)};
        m_acc = valid && (!m_busy || last);
        if (m_acc) begin
            m_busy = 1'b1;
            m_word = {^data, data};
            m_idx  = 0;
        end else if (last) begin
            m_busy = 1'b0;
            m_idx  = 0;
        end else if (m_busy && tick) begin
            m_idx++;
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; shift_tick = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
        #3;
        cmp++;
        if ({s_out, busy, done, in_ready} !== 4'b0001) begin
            err++; $display("FAIL reset_init got %b want %b", {s_out, busy, done, in_ready}, 4'b0001);
        end
        @(posedge clk); #1;
        rst = 1'b0; m_busy = 1'b0; m_idx = 0;
        apply(1'b0, 1'b1, 8'hA5);
        cmp++;
        if ({s_out, busy, done, in_ready} !== exp_v) begin
            err++; $display("FAIL reset_accept got %b want %b", {s_out, busy, done, in_ready}, exp_v);
        end
        next_cycle();
        for (int c = 1; c <= 14; c++) begin
            apply((c % 4) == 0, 1'b0, 8'h00);
            cmp++;
            if ({s_out, busy, done, in_ready} !== exp_v) begin
                err++; $display("FAIL reset_preframe c=%0d got %b want %b", c, {s_out, busy, done, in_ready}, exp_v);
            end
            if (c < 14) next_cycle();
        end
        #2;
        rst = 1'b1; shift_tick = 1'b1;
        #1;
        cmp++;
        if ({s_out, busy, done, in_ready} !== 4'b0001) begin
            err++; $display("FAIL reset_async got %b want %b", {s_out, busy, done, in_ready}, 4'b0001);
        end
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #2;
            cmp++;
            if ({s_out, busy, done, in_ready} !== 4'b0001) begin
                err++; $display("FAIL reset_hold c=%0d got %b want %b", c, {s_out, busy, done, in_ready}, 4'b0001);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0; m_busy = 1'b0; m_idx = 0;
        apply(1'b1, 1'b0, 8'h00);
        cmp++;
        if ({s_out, busy, done, in_ready} !== exp_v) begin
            err++; $display("FAIL reset_release got %b want %b", {s_out, busy, done, in_ready}, exp_v);
        end
        next_cycle();
    endtask

    task automatic test_a5();
        int         dones = 0;
        int         nt = 0;
        logic [7:0] cap = '0;
        apply(1'b0, 1'b1, 8'hA5);
        cmp++;
        if ({s_out, busy, done, in_ready} !== exp_v) begin
            err++; $display("FAIL a5_accept got %b want %b", {s_out, busy, done, in_ready}, exp_v);
        end
        next_cycle();
        for (int c = 1; c <= 40; c++) begin
            apply((c % 4) == 0, 1'b0, 8'h00);
            cmp++;
            if ({s_out, busy, done, in_ready} !== exp_v) begin
                err++; $display("FAIL a5_cycle c=%0d got %b want %b", c, {s_out, busy, done, in_ready}, exp_v);
            end
            if (done) dones++;
            if (shift_tick && busy && nt < 8) begin cap[nt] = s_out; nt++; end
            next_cycle();
        end
        cmp++;
        if (cap !== 8'hA5) begin
            err++; $display("FAIL a5_serial got %h want %h", cap, 8'hA5);
        end
        cmp++;
        if (dones !== 1) begin
            err++; $display("FAIL a5_done_count got %0d want %0d", dones, 1);
        end
    endtask

    task automatic test_back_to_back();
        int          dones = 0;
        int          acc = 0;
        int          nt = 0;
        logic [7:0]  data = 8'h01;
        logic [15:0] cap = '0;
        apply(1'b0, 1'b1, data);
        cmp++;
        if ({s_out, busy, done, in_ready} !== exp_v) begin
            err++; $display("FAIL b2b_accept got %b want %b", {s_out, busy, done, in_ready}, exp_v);
        end
        if (m_acc) begin acc++; data = 8'hFF; end
        next_cycle();
        for (int c = 1; c <= 80; c++) begin
            apply((c % 4) == 0, acc < 2, data);
            cmp++;
            if ({s_out, busy, done, in_ready} !== exp_v) begin
                err++; $display("FAIL b2b_cycle c=%0d got %b want %b", c, {s_out, busy, done, in_ready}, exp_v);
            end
            if (m_acc) begin acc++; data = 8'hFF; end
            if (done) dones++;
            if (shift_tick && busy && nt < 16) begin cap[nt] = s_out; nt++; end
            next_cycle();
        end
        cmp++;
        if (dones !== 2) begin
            err++; $display("FAIL b2b_done_count got %0d want %0d", dones, 2);
        end
`ifndef PISO_PARITY_EN
        cmp++;
        if (cap !== 16'hFF01) begin
            err++; $display("FAIL b2b_serial got %h want %h", cap, 16'hFF01);
        end
`endif
    endtask

    task automatic test_idle_hold();
        int         nt = 0;
        logic [7:0] cap = '0;
        logic       tk;
        for (int c = 0; c < 8; c++) begin
            apply((c % 2) == 1, 1'b0, 8'(c * 37));
            cmp++;
            if ({s_out, busy, done, in_ready} !== 4'b0001) begin
                err++; $display("FAIL idle_ticks c=%0d got %b want %b", c, {s_out, busy, done, in_ready}, 4'b0001);
            end
            next_cycle();
        end
        apply(1'b0, 1'b1, 8'h3C);
        cmp++;
        if ({s_out, busy, done, in_ready} !== exp_v) begin
            err++; $display("FAIL hold_accept got %b want %b", {s_out, busy, done, in_ready}, exp_v);
        end
        next_cycle();
        for (int c = 1; c <= 40; c++) begin
            tk = (c % 4) == 0;
            apply(tk, !tk && (c < 32), 8'($urandom));
            cmp++;
            if ({s_out, busy, done, in_ready} !== exp_v) begin
                err++; $display("FAIL hold_cycle c=%0d got %b want %b", c, {s_out, busy, done, in_ready}, exp_v);
            end
            if (shift_tick && busy && nt < 8) begin cap[nt] = s_out; nt++; end
            next_cycle();
        end
        cmp++;
        if (cap !== 8'h3C) begin
            err++; $display("FAIL hold_serial got %h want %h", cap, 8'h3C);
        end
    endtask

    task automatic test_fast_tick();
        int         nt = 0;
        logic [7:0] cap = '0;
        apply(1'b1, 1'b1, 8'h59);
        cmp++;
        if ({s_out, busy, done, in_ready} !== exp_v) begin
            err++; $display("FAIL fast_accept got %b want %b", {s_out, busy, done, in_ready}, exp_v);
        end
        next_cycle();
        for (int c = 1; c <= 12; c++) begin
            apply(1'b1, 1'b0, 8'h00);
            cmp++;
            if ({s_out, busy, done, in_ready} !== exp_v) begin
                err++; $display("FAIL fast_cycle c=%0d got %b want %b", c, {s_out, busy, done, in_ready}, exp_v);
            end
            if (busy && nt < 8) begin cap[nt] = s_out; nt++; end
            next_cycle();
        end
        cmp++;
        if (cap !== 8'h59) begin
            err++; $display("FAIL fast_serial got %h want %h", cap, 8'h59);
        end
    endtask

`ifdef PISO_PARITY_EN
    task automatic test_parity(input logic [7:0] word, input logic [8:0] want);
        int         nt = 0;
        int         done_at = -1;
        logic [8:0] cap = '0;
        apply(1'b0, 1'b1, word);
        cmp++;
        if ({s_out, busy, done, in_ready} !== exp_v) begin
            err++; $display("FAIL par_accept got %b want %b", {s_out, busy, done, in_ready}, exp_v);
        end
        next_cycle();
        for (int c = 1; c <= 40; c++) begin
            apply((c % 4) == 0, 1'b0, 8'h00);
            cmp++;
            if ({s_out, busy, done, in_ready} !== exp_v) begin
                err++; $display("FAIL par_cycle c=%0d got %b want %b", c, {s_out, busy, done, in_ready}, exp_v);
            end
            if (done) done_at = c;
            if (shift_tick && busy && nt < 9) begin cap[nt] = s_out; nt++; end
            next_cycle();
        end
        cmp++;
        if (cap !== want) begin
            err++; $display("FAIL par_serial got %h want %h", cap, want);
        end
        cmp++;
        if (done_at !== 36) begin
            err++; $display("FAIL par_done_cycle got %0d want %0d", done_at, 36);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_a5();
        test_back_to_back();
        test_idle_hold();
        test_fast_tick();
`ifdef PISO_PARITY_EN
        test_parity(8'h07, 9'h107);
        test_parity(8'h03, 9'h003);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end

endmodule
